// File: rtl/arp_step_seq_if.sv
// Handshake bundle between the arpeggiator step sequencer, the rate trigger
// generator and the downstream voice stage.
interface arp_step_seq_if #(
    parameter int NUM_CHANNELS = 16,
    parameter int IDX_W        = 4
);
    logic                    trigger;
    logic [NUM_CHANNELS-1:0] note_mask;
    logic [1:0]              mode;
    logic                    trig_en;
    logic [IDX_W-1:0]        note_idx;
    logic                    note_valid;
    logic                    step_pulse;

    modport master (
        output trigger, note_mask, mode,
        input  trig_en, note_idx, note_valid, step_pulse
    );

    modport slave (
        input  trigger, note_mask, mode,
        output trig_en, note_idx, note_valid, step_pulse
    );
endinterface

// File: rtl/arp_step_seq.sv
// Arpeggiator step sequencer: advances through held notes in up/down/up-down
// order on each rising edge of the rate trigger.
module arp_step_seq #(
    parameter int NUM_CHANNELS = 16,
    parameter int IDX_W        = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    arp_step_seq_if.slave   bus
);
    typedef enum logic { IDLE, RUN } state_t;

    localparam logic [1:0] MODE_DOWN   = 2'd1;
    localparam logic [1:0] MODE_UPDOWN = 2'd2;

    state_t           state, state_nx;
    logic [IDX_W-1:0] note_idx, idx_nx;
    logic             dir_up, dir_nx;
    logic             pulse, pulse_nx;
    logic             trig_d;
    logic             trig_edge;

    logic [NUM_CHANNELS-1:0] mask;
    logic [IDX_W-1:0]        lo, hi, up_nx, dn_nx;
    logic                    up_ok, dn_ok;

    assign mask      = bus.note_mask;
    assign trig_edge = bus.trigger & ~trig_d;

    // Nearest held note strictly above / below the current index, plus the
    // extreme held notes used for wrap-around and for the start note.
    always_comb begin
        lo    = '0;
        hi    = '0;
        up_nx = '0;
        dn_nx = '0;
        up_ok = 1'b0;
        dn_ok = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i]) lo = IDX_W'(i);
            if (mask[i] && i > int'(note_idx)) begin
                up_nx = IDX_W'(i);
                up_ok = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (mask[i]) hi = IDX_W'(i);
            if (mask[i] && i < int'(note_idx)) begin
                dn_nx = IDX_W'(i);
                dn_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = note_idx;
        dir_nx   = dir_up;
        pulse_nx = 1'b0;
        case (state)
            IDLE: begin
                if (|mask) begin
                    state_nx = RUN;
                    pulse_nx = 1'b1;
                    if (bus.mode == MODE_DOWN) begin
                        idx_nx = hi;
                        dir_nx = 1'b0;
                    end else begin
                        idx_nx = lo;
                        dir_nx = 1'b1;
                    end
                end
            end
            RUN: begin
                // An empty mask wins over a coincident edge.
                if (~|mask) begin
                    state_nx = IDLE;
                end else if (trig_edge) begin
                    pulse_nx = 1'b1;
                    case (bus.mode)
                        MODE_DOWN: begin
                            dir_nx = 1'b0;
                            idx_nx = dn_ok ? dn_nx : hi;
                        end
                        MODE_UPDOWN: begin
                            // Reverse at an endpoint without repeating it.
                            if (dir_up) begin
                                if (up_ok) idx_nx = up_nx;
                                else begin
                                    dir_nx = 1'b0;
                                    if (dn_ok) idx_nx = dn_nx;
                                end
                            end else begin
                                if (dn_ok) idx_nx = dn_nx;
                                else begin
                                    dir_nx = 1'b1;
                                    if (up_ok) idx_nx = up_nx;
                                end
                            end
                        end
                        default: begin
                            dir_nx = 1'b1;
                            idx_nx = up_ok ? up_nx : lo;
                        end
                    endcase
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // trig_d resets high so a trigger already high out of reset is not an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            note_idx <= '0;
            dir_up   <= 1'b1;
            pulse    <= 1'b0;
            trig_d   <= 1'b1;
        end else begin
            state    <= state_nx;
            note_idx <= idx_nx;
            dir_up   <= dir_nx;
            pulse    <= pulse_nx;
            trig_d   <= bus.trigger;
        end
    end

    assign bus.note_idx   = note_idx;
    assign bus.step_pulse = pulse;
    assign bus.note_valid = (state == RUN);
    assign bus.trig_en    = (state == RUN);
endmodule

// File: tb/tb_arp_step_seq.sv
// Bench for arp_step_seq: directed pattern scenarios plus randomized traffic
// compared against a held-note-list reference model.
module tb_arp_step_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    arp_step_seq_if #(.NUM_CHANNELS(16), .IDX_W(4)) bus ();

    arp_step_seq #(.NUM_CHANNELS(16), .IDX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit m_run    = 1'b0;
    int m_idx    = 0;
    bit m_dir_up = 1'b1;
    bit m_trig_d = 1'b1;
    bit m_pulse  = 1'b0;

    task automatic model_step();
        bit e;
        int held[$];
        int ab, bl;
        bit ab_ok, bl_ok;
        e = bus.trigger && !m_trig_d;
        m_trig_d = bus.trigger;
        if (!rst_n) begin
            m_run = 0; m_idx = 0; m_dir_up = 1; m_trig_d = 1; m_pulse = 0;
            return;
        end
        m_pulse = 0;
        for (int i = 0; i < 16; i++) if (bus.note_mask[i]) held.push_back(i);
        if (!m_run) begin
            if (held.size() > 0) begin
                m_run = 1; m_pulse = 1;
                if (bus.mode == 2'd1) begin m_idx = held[held.size()-1]; m_dir_up = 0; end
                else begin m_idx = held[0]; m_dir_up = 1; end
            end
        end else if (held.size() == 0) begin
            m_run = 0;
        end else if (e) begin
            m_pulse = 1;
            ab = 0; bl = 0; ab_ok = 0; bl_ok = 0;
            foreach (held[k]) begin
                if (held[k] > m_idx && !ab_ok) begin ab = held[k]; ab_ok = 1; end
                if (held[k] < m_idx) begin bl = held[k]; bl_ok = 1; end
            end
            if (bus.mode == 2'd2) begin
                if (m_dir_up ? !ab_ok : !bl_ok) m_dir_up = !m_dir_up;
                if (m_dir_up && ab_ok) m_idx = ab;
                else if (!m_dir_up && bl_ok) m_idx = bl;
            end else if (bus.mode == 2'd1) begin
                m_dir_up = 0;
                m_idx = bl_ok ? bl : held[held.size()-1];
            end else begin
                m_dir_up = 1;
                m_idx = ab_ok ? ab : held[0];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic go_idle();
        bus.note_mask = '0;
        bus.trigger = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.trigger = 1'b1; bus.note_mask = '0; bus.mode = 2'd0;
        repeat (3) tick();
        checks++;
        if (bus.note_idx !== 4'd0 || bus.note_valid !== 1'b0 || bus.step_pulse !== 1'b0 || bus.trig_en !== 1'b0) begin
            errors++;
            $display("FAIL reset: idx=%0d valid=%0b pulse=%0b en=%0b want all 0",
                     bus.note_idx, bus.note_valid, bus.step_pulse, bus.trig_en);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.step_pulse !== 1'b0 || bus.note_valid !== 1'b0 || bus.trig_en !== 1'b0) begin
                errors++;
                $display("FAIL post_reset cyc%0d: pulse=%0b valid=%0b en=%0b want 0", c,
                         bus.step_pulse, bus.note_valid, bus.trig_en);
            end
        end
        bus.trigger = 1'b0;
        tick();
    endtask

    task automatic test_pattern(input string name, input logic [1:0] md, input logic [15:0] mk,
                                input int start, input int exp[6], input int n);
        go_idle();
        bus.mode = md;
        bus.note_mask = mk;
        tick();
        checks++;
        if (bus.note_idx !== 4'(start) || bus.step_pulse !== 1'b1 || bus.trig_en !== 1'b1 || bus.note_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s start: idx=%0d pulse=%0b en=%0b valid=%0b want idx=%0d pulse=1 en=1 valid=1",
                     name, bus.note_idx, bus.step_pulse, bus.trig_en, bus.note_valid, start);
        end
        tick();
        for (int k = 0; k < n; k++) begin
            bus.trigger = 1'b1;
            tick();
            checks++;
            if (bus.note_idx !== 4'(exp[k]) || bus.step_pulse !== 1'b1) begin
                errors++;
                $display("FAIL %s step%0d: idx=%0d pulse=%0b want idx=%0d pulse=1",
                         name, k, bus.note_idx, bus.step_pulse, exp[k]);
            end
            tick();
            checks++;
            if (bus.note_idx !== 4'(exp[k]) || bus.step_pulse !== 1'b0) begin
                errors++;
                $display("FAIL %s hold%0d: idx=%0d pulse=%0b want idx=%0d pulse=0",
                         name, k, bus.note_idx, bus.step_pulse, exp[k]);
            end
            bus.trigger = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_release();
        go_idle();
        bus.mode = 2'd0;
        bus.note_mask = 16'h0025;
        tick();
        bus.trigger = 1'b1; tick();
        bus.trigger = 1'b0; tick();
        checks++;
        if (bus.note_idx !== 4'd2) begin
            errors++;
            $display("FAIL release pre: idx=%0d want 2", bus.note_idx);
        end
        bus.note_mask = 16'h0001;
        bus.trigger = 1'b1; tick();
        checks++;
        if (bus.note_idx !== 4'd0 || bus.step_pulse !== 1'b1) begin
            errors++;
            $display("FAIL release skip: idx=%0d pulse=%0b want idx=0 pulse=1", bus.note_idx, bus.step_pulse);
        end
        bus.trigger = 1'b0; tick();
        bus.note_mask = '0;
        bus.trigger = 1'b1; tick();
        checks++;
        if (bus.note_valid !== 1'b0 || bus.step_pulse !== 1'b0 || bus.trig_en !== 1'b0) begin
            errors++;
            $display("FAIL release empty: valid=%0b pulse=%0b en=%0b want 0",
                     bus.note_valid, bus.step_pulse, bus.trig_en);
        end
        bus.trigger = 1'b0; tick();
    endtask

    task automatic test_reset_midrun();
        go_idle();
        bus.mode = 2'd0;
        bus.note_mask = 16'h0025;
        tick();
        bus.trigger = 1'b1; tick();
        bus.trigger = 1'b0; tick();
        bus.trigger = 1'b1;
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.note_idx !== 4'd0 || bus.note_valid !== 1'b0 || bus.step_pulse !== 1'b0 || bus.trig_en !== 1'b0) begin
            errors++;
            $display("FAIL midrun reset: idx=%0d valid=%0b pulse=%0b en=%0b want all 0",
                     bus.note_idx, bus.note_valid, bus.step_pulse, bus.trig_en);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.note_idx !== 4'd0 || bus.step_pulse !== 1'b1 || bus.note_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrun restart: idx=%0d pulse=%0b valid=%0b want idx=0 pulse=1 valid=1",
                     bus.note_idx, bus.step_pulse, bus.note_valid);
        end
        bus.trigger = 1'b0; tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.note_mask = '0;
                    1:       bus.note_mask = 16'(1 << $urandom_range(0, 15));
                    2:       bus.note_mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
                    default: bus.note_mask = 16'($urandom);
                endcase
            end
            if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) bus.trigger = ~bus.trigger;
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
            checks++;
            if (bus.note_idx !== 4'(m_idx) || bus.step_pulse !== m_pulse ||
                bus.note_valid !== m_run || bus.trig_en !== m_run) begin
                errors++;
                $display("FAIL random cyc%0d: idx=%0d pulse=%0b valid=%0b en=%0b want idx=%0d pulse=%0b valid=%0b en=%0b",
                         c, bus.note_idx, bus.step_pulse, bus.note_valid, bus.trig_en,
                         m_idx, m_pulse, m_run, m_run);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bus.trigger = 1'b0;
        bus.note_mask = '0;
        bus.mode = 2'd0;
        test_reset();
        test_pattern("up",     2'd0, 16'h0025, 0, '{2, 5, 0, 2, 0, 0}, 4);
        test_pattern("down",   2'd1, 16'h0025, 5, '{2, 0, 5, 0, 0, 0}, 3);
        test_pattern("updown", 2'd2, 16'h0025, 0, '{2, 5, 2, 0, 2, 0}, 5);
        test_pattern("single", 2'd2, 16'h0008, 3, '{3, 3, 3, 0, 0, 0}, 3);
        test_pattern("rsvd",   2'd3, 16'h8102, 1, '{8, 15, 1, 0, 0, 0}, 3);
        test_release();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
